// File: rtl/axi_lite_burst_sequencer_if.sv
// Command, write-data stream, read-data stream and AXI4-Lite master signals
// of the burst sequencer, bundled for connection between sequencer and system.
interface axi_lite_burst_sequencer_if #(
    parameter int unsigned AddrWidth = 32'd8,
    parameter int unsigned DataWidth = 32'd32,
    parameter int unsigned LenWidth  = 32'd4
);
    logic                   cmd_valid_i;
    logic                   cmd_ready_o;
    logic                   cmd_write_i;
    logic [AddrWidth-1:0]   cmd_addr_i;
    logic [LenWidth-1:0]    cmd_len_i;

    logic                   wd_valid_i;
    logic                   wd_ready_o;
    logic [DataWidth-1:0]   wd_data_i;

    logic                   rd_valid_o;
    logic [DataWidth-1:0]   rd_data_o;
    logic                   done_o;
    logic                   err_o;

    logic [AddrWidth-1:0]   aw_addr_o;
    logic                   aw_valid_o;
    logic                   aw_ready_i;
    logic [DataWidth-1:0]   w_data_o;
    logic [DataWidth/8-1:0] w_strb_o;
    logic                   w_valid_o;
    logic                   w_ready_i;
    logic [1:0]             b_resp_i;
    logic                   b_valid_i;
    logic                   b_ready_o;
    logic [AddrWidth-1:0]   ar_addr_o;
    logic                   ar_valid_o;
    logic                   ar_ready_i;
    logic [DataWidth-1:0]   r_data_i;
    logic [1:0]             r_resp_i;
    logic                   r_valid_i;
    logic                   r_ready_o;

    modport master (
        input  cmd_valid_i, cmd_write_i, cmd_addr_i, cmd_len_i,
        input  wd_valid_i, wd_data_i,
        input  aw_ready_i, w_ready_i, b_resp_i, b_valid_i,
        input  ar_ready_i, r_data_i, r_resp_i, r_valid_i,
        output cmd_ready_o, wd_ready_o, rd_valid_o, rd_data_o, done_o, err_o,
        output aw_addr_o, aw_valid_o, w_data_o, w_strb_o, w_valid_o, b_ready_o,
        output ar_addr_o, ar_valid_o, r_ready_o
    );

    modport slave (
        output cmd_valid_i, cmd_write_i, cmd_addr_i, cmd_len_i,
        output wd_valid_i, wd_data_i,
        output aw_ready_i, w_ready_i, b_resp_i, b_valid_i,
        output ar_ready_i, r_data_i, r_resp_i, r_valid_i,
        input  cmd_ready_o, wd_ready_o, rd_valid_o, rd_data_o, done_o, err_o,
        input  aw_addr_o, aw_valid_o, w_data_o, w_strb_o, w_valid_o, b_ready_o,
        input  ar_addr_o, ar_valid_o, r_ready_o
    );
endinterface

// File: rtl/axi_lite_burst_sequencer.sv
// Splits one "write/read N words at A" command into sequential single-beat
// AXI4-Lite transactions, one outstanding at a time.
//
// state   | meaning
// IDLE    | ready for a command
// WR_REQ  | AW and W handshakes in flight (either order)
// WR_RESP | waiting for B
// RD_REQ  | AR in flight
// RD_DATA | waiting for R
// DONE    | one-cycle done/err pulse
module axi_lite_burst_sequencer #(
    parameter int unsigned AddrWidth = 32'd8,
    parameter int unsigned DataWidth = 32'd32,
    parameter int unsigned LenWidth  = 32'd4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    axi_lite_burst_sequencer_if.master bus
);
    localparam logic [AddrWidth-1:0] AddrStep  = AddrWidth'(DataWidth / 8);
    localparam logic [AddrWidth-1:0] AlignMask = ~(AddrStep - AddrWidth'(1));

    typedef enum logic [2:0] {
        IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, DONE
    } state_t;

    state_t               state;
    logic [AddrWidth-1:0] addr_q;
    logic [LenWidth-1:0]  count_q;
    logic                 aw_done;
    logic                 w_done;
    logic                 err_q;
    logic                 rd_valid_q;
    logic [DataWidth-1:0] rd_data_q;

    logic aw_hs, w_hs, b_hs, ar_hs, r_hs, last_beat;

    assign bus.cmd_ready_o = (state == IDLE) && !rst_i;
    assign bus.aw_addr_o   = addr_q;
    assign bus.ar_addr_o   = addr_q;
    assign bus.aw_valid_o  = (state == WR_REQ) && !aw_done;
    // W side is a straight pass-through of the stream so one W beat eats one word
    assign bus.w_valid_o   = (state == WR_REQ) && bus.wd_valid_i && !w_done;
    assign bus.wd_ready_o  = (state == WR_REQ) && bus.w_ready_i && !w_done;
    assign bus.w_data_o    = bus.wd_data_i;
    assign bus.w_strb_o    = '1;
    assign bus.b_ready_o   = (state == WR_RESP);
    assign bus.ar_valid_o  = (state == RD_REQ);
    assign bus.r_ready_o   = (state == RD_DATA);
    assign bus.rd_valid_o  = rd_valid_q;
    assign bus.rd_data_o   = rd_data_q;
    assign bus.done_o      = (state == DONE);
    assign bus.err_o       = (state == DONE) && err_q;

    assign aw_hs     = bus.aw_valid_o && bus.aw_ready_i;
    assign w_hs      = bus.w_valid_o && bus.w_ready_i;
    assign b_hs      = bus.b_ready_o && bus.b_valid_i;
    assign ar_hs     = bus.ar_valid_o && bus.ar_ready_i;
    assign r_hs      = bus.r_ready_o && bus.r_valid_i;
    assign last_beat = (count_q == '0);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= IDLE;
            addr_q     <= '0;
            count_q    <= '0;
            aw_done    <= 1'b0;
            w_done     <= 1'b0;
            err_q      <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            rd_valid_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.cmd_valid_i) begin
                        addr_q  <= bus.cmd_addr_i & AlignMask;
                        count_q <= bus.cmd_len_i;
                        err_q   <= 1'b0;
                        aw_done <= 1'b0;
                        w_done  <= 1'b0;
                        state   <= bus.cmd_write_i ? WR_REQ : RD_REQ;
                    end
                end
                WR_REQ: begin
                    if ((aw_done || aw_hs) && (w_done || w_hs)) begin
                        aw_done <= 1'b0;
                        w_done  <= 1'b0;
                        state   <= WR_RESP;
                    end else begin
                        if (aw_hs) aw_done <= 1'b1;
                        if (w_hs)  w_done  <= 1'b1;
                    end
                end
                WR_RESP: begin
                    if (b_hs) begin
                        err_q <= err_q || (bus.b_resp_i != 2'b00);
                        if (last_beat) begin
                            state <= DONE;
                        end else begin
                            addr_q  <= addr_q + AddrStep;
                            count_q <= count_q - LenWidth'(1);
                            state   <= WR_REQ;
                        end
                    end
                end
                RD_REQ: begin
                    if (ar_hs) state <= RD_DATA;
                end
                RD_DATA: begin
                    if (r_hs) begin
                        rd_data_q  <= bus.r_data_i;
                        rd_valid_q <= 1'b1;
                        err_q      <= err_q || (bus.r_resp_i != 2'b00);
                        if (last_beat) begin
                            state <= DONE;
                        end else begin
                            addr_q  <= addr_q + AddrStep;
                            count_q <= count_q - LenWidth'(1);
                            state   <= RD_REQ;
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/axi_lite_burst_sequencer.md
Name: axi_lite_burst_sequencer

Overview:
- Command-driven AXI4-Lite master that splits one multi-beat request into sequential single-beat AXI4-Lite transactions.
- Sits in front of the AXI4-Lite data-width converter slave port.
- A local engine issues "write/read N words starting at A"; the sequencer generates the AW/W/B or AR/R handshakes one beat at a time, incrementing the address.

Parameters:
- AddrWidth, 32'd8: AXI4-Lite address width.
- DataWidth, 32'd32: AXI4-Lite data width; power of two, >= 8.
- LenWidth, 32'd4: width of the beat-count field; beats = cmd_len_i + 1.

Ports:
- clk_i  in  1  clock, positive edge triggered.
- rst_i  in  1  asynchronous reset, active high.
- cmd_valid_i  in  1  command valid.
- cmd_ready_o  out  1  command accepted when high with cmd_valid_i.
- cmd_write_i  in  1  1 = write burst, 0 = read burst.
- cmd_addr_i  in  AddrWidth  start byte address; low log2(DataWidth/8) bits are cleared internally.
- cmd_len_i  in  LenWidth  number of beats minus 1.
- wd_valid_i  in  1  write-data stream valid.
- wd_ready_o  out  1  write-data stream ready.
- wd_data_i  in  DataWidth  write-data word.
- rd_valid_o  out  1  read-data pulse; no backpressure.
- rd_data_o  out  DataWidth  read-data word, valid with rd_valid_o.
- done_o  out  1  one-cycle pulse when the burst completes.
- err_o  out  1  high with done_o if any beat returned resp != OKAY.
- aw_addr_o  out  AddrWidth  AW address.
- aw_valid_o  out  1  AW valid.
- aw_ready_i  in  1  AW ready.
- w_data_o  out  DataWidth  W data, equal to wd_data_i.
- w_strb_o  out  DataWidth/8  W strobe, all ones.
- w_valid_o  out  1  W valid.
- w_ready_i  in  1  W ready.
- b_resp_i  in  2  B response.
- b_valid_i  in  1  B valid.
- b_ready_o  out  1  B ready.
- ar_addr_o  out  AddrWidth  AR address.
- ar_valid_o  out  1  AR valid.
- ar_ready_i  in  1  AR ready.
- r_data_i  in  DataWidth  R data.
- r_resp_i  in  2  R response.
- r_valid_i  in  1  R valid.
- r_ready_o  out  1  R ready.

Behaviour:
- Clocking and reset: one clock, clk_i; asynchronous active-high reset, rst_i.
- Reset (immediate, asynchronous): state IDLE; all valid, ready, done and err outputs 0; cmd_ready_o is 0 while rst_i is high; address and count registers 0. Reset during a burst abandons it without a done_o pulse; dropping valids mid-handshake is accepted only under reset.
- FSM states: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, DONE.
- IDLE: cmd_ready_o=1. On cmd_valid_i, latch the aligned address, count=cmd_len_i and the write flag; clear the sticky error; go to WR_REQ or RD_REQ. Commands are not accepted in any other state.
- WR_REQ:
  - aw_valid_o stays high until the AW handshake; an aw_done flag is then set.
  - w_valid_o = wd_valid_i & ~w_done; wd_ready_o = w_ready_i & ~w_done. Combinational pass-through, so a W handshake consumes exactly one stream word.
  - AW and W handshake independently, in either order or the same cycle. When both are done, clear the flags and go to WR_RESP.
- WR_RESP: b_ready_o=1. On the B handshake, OR (b_resp_i != 2'b00) into the sticky error.
- RD_REQ: ar_valid_o stays high until the AR handshake, then RD_DATA.
- RD_DATA: r_ready_o=1. On the R handshake, register r_data_i into rd_data_o and pulse rd_valid_o the next cycle; OR (r_resp_i != 2'b00) into the sticky error.
- End of beat: if count==0, go to DONE. Otherwise address += DataWidth/8 (modulo 2^AddrWidth, wraps silently), count -= 1, return to WR_REQ/RD_REQ.
- Errors never abort: all cmd_len_i+1 beats are always issued.
- DONE: done_o=1 and err_o=sticky error for exactly one cycle, then IDLE. cmd_ready_o rises the cycle after done_o.
- Outstanding transactions: at most one at any time.
- Minimum latency per beat, slave always ready: write 2 cycles (REQ, RESP), read 2 cycles.

Test Plan:
- Write, cmd_addr 0x10, len 2, wd words 0xA/0xB/0xC, slave always ready, OKAY -> AW addrs 0x10/0x14/0x18 with W data 0xA/0xB/0xC in order; one done_o pulse with err_o=0; exactly 3 wd handshakes.
- Read, addr 0x20, len 0, r_data 0xDEADBEEF -> single AR at 0x20; one rd_valid_o pulse carrying 0xDEADBEEF; then done_o with err_o=0.
- Write with aw_ready_i held low 3 cycles, w_ready_i high -> W handshake first, then w_valid_o drops; no second wd word consumed; b_ready_o only after the AW handshake.
- Read, len 3, beat 1 returns SLVERR (2'b10) -> all 4 ARs issued, 4 rd_valid_o pulses, done_o with err_o=1; next OKAY-only command gives err_o=0.
- Address handling, cmd_addr 0xFD, len 1 -> addresses 0xFC then 0x00 (alignment plus wrap).
- rst_i asserted during WR_RESP -> all valids and b_ready_o go 0 immediately; no done_o; after release, cmd_ready_o=1 and a new command runs normally.
